// File: rtl/disp_pkg.sv
// Shared definitions for the BCD display driver.
//   - FSM state encoding for the binary-to-BCD converter
//   - active-low seven-segment glyph constants (seg[0]=a .. seg[6]=g)
//   - digit codes 10/11 used for the dash and blank glyphs
//   - conversion constants and the double-dabble nibble adjust helper
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int VALUE_W     = 10;
  localparam int MAX_DISPLAY = 999;
  localparam int CONV_CYCLES = 10;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  // Add 3 to every BCD nibble that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-code to seven-segment glyph decoder.
//   code : 4-bit digit code, 0..9 decimal, 10 = dash, 11 = blank
//   seg  : active-low segments, seg[0]=a .. seg[6]=g
// Codes above 11 decode to blank.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (code)
      4'd0:       seg = GLYPH_0;
      4'd1:       seg = GLYPH_1;
      4'd2:       seg = GLYPH_2;
      4'd3:       seg = GLYPH_3;
      4'd4:       seg = GLYPH_4;
      4'd5:       seg = GLYPH_5;
      4'd6:       seg = GLYPH_6;
      4'd7:       seg = GLYPH_7;
      4'd8:       seg = GLYPH_8;
      4'd9:       seg = GLYPH_9;
      CODE_DASH:  seg = GLYPH_DASH;
      default:    seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Three-digit seven-segment display driver with binary-to-BCD conversion.
// A value_valid strobe starts a 10-cycle double-dabble conversion; the
// result is committed to the three display digit registers in one cycle,
// so the display never shows a partial result. Values above 999 show
// three dashes. The display side is registered: an/seg follow digit by
// one cycle.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   digit[1:0]  : digit being scanned (0 ones, 1 tens, 2 hundreds, 3 none)
//   value[9:0]  : unsigned binary value to display
//   value_valid : single-cycle conversion request (ignored while busy)
//   busy        : conversion in progress (SHIFT and COMMIT)
//   done        : single-cycle pulse when new digits are committed
//   an[3:0]     : active-low anode enables
//   seg[6:0]    : active-low segments, seg[0]=a .. seg[6]=g
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros in
// the hundreds and tens positions (the ones digit and dashes are never
// blanked).
module bcd_display_driver
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] digit,
  input  logic [9:0] value,
  input  logic       value_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  state_t state, state_next;

  logic [3:0]         shift_cnt;
  logic [VALUE_W-1:0] shift_reg;
  logic [11:0]        scratch;
  logic               ovf;

  logic [3:0] dig_ones, dig_tens, dig_hund;

  logic [3:0] code_sel;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (value_valid) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (shift_cnt == 4'(CONV_CYCLES - 1)) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy = 1'b1;
        // A reset landing on the commit cycle abandons it, pulse included.
        done       = ~reset;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Conversion datapath: capture, then one double-dabble step per cycle
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (value_valid) begin
          shift_reg <= value;
          scratch   <= '0;
          shift_cnt <= '0;
          ovf       <= (value > VALUE_W'(MAX_DISPLAY));
        end
      end
      ST_SHIFT: begin
        {scratch, shift_reg} <= {dabble_adjust(scratch), shift_reg} << 1;
        shift_cnt            <= shift_cnt + 4'd1;
      end
      default: ;
    endcase
  end

  // Commit stage: all three digits update together
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_ones <= '0;
      dig_tens <= '0;
      dig_hund <= '0;
    end else if (state == ST_COMMIT) begin
      if (ovf) begin
        dig_ones <= CODE_DASH;
        dig_tens <= CODE_DASH;
        dig_hund <= CODE_DASH;
      end else begin
        dig_ones <= scratch[3:0];
        dig_tens <= scratch[7:4];
        dig_hund <= scratch[11:8];
      end
    end
  end

  // Digit select; dash codes are nonzero so blanking never hides them
  always_comb begin
    code_sel = CODE_BLANK;
    an_next  = 4'b1111;
    case (digit)
      2'd0: begin
        code_sel = dig_ones;
        an_next  = 4'b1110;
      end
      2'd1: begin
        code_sel = dig_tens;
        an_next  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        if (dig_hund == 4'd0 && dig_tens == 4'd0) code_sel = CODE_BLANK;
`endif
      end
      2'd2: begin
        code_sel = dig_hund;
        an_next  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
        if (dig_hund == 4'd0) code_sel = CODE_BLANK;
`endif
      end
      default: begin
        code_sel = CODE_BLANK;
        an_next  = 4'b1111;
      end
    endcase
  end

  seg_decoder u_seg_decoder (
    .code (code_sel),
    .seg  (seg_next)
  );

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= GLYPH_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed, table-driven bench for bcd_display_driver. Expected glyphs are
// hand-written; the LEADING_ZERO_BLANK_EN build selects the blanked columns.
module tb_bcd_display_driver;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;

  typedef struct {
    logic [9:0] value;
    logic [6:0] h;
    logic [6:0] t;
    logic [6:0] o;
    logic [6:0] h_lzb;
    logic [6:0] t_lzb;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] digit;
  logic [9:0] value;
  logic       value_valid;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs[12];

  bcd_display_driver dut (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .done        (done),
    .an          (an),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic show(input logic [1:0] k, output logic [6:0] s, output logic [3:0] a);
    digit = k;
    tick();
    s = seg;
    a = an;
  endtask

  // Strobe one value and watch the following 15 cycles.
  task automatic convert(input logic [9:0] v, output int busy_cnt,
                         output int done_cnt, output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      tick();
    end
  endtask

  task automatic check_display(input string tag, input logic [6:0] eh,
                               input logic [6:0] et, input logic [6:0] eo);
    logic [6:0] s;
    logic [3:0] a;
    show(2'd2, s, a);
    chk({tag, " hund seg"}, 32'(s), 32'(eh));
    chk({tag, " hund an"},  32'(a), 32'(4'b1011));
    show(2'd1, s, a);
    chk({tag, " tens seg"}, 32'(s), 32'(et));
    show(2'd0, s, a);
    chk({tag, " ones seg"}, 32'(s), 32'(eo));
    chk({tag, " ones an"},  32'(a), 32'(4'b1110));
  endtask

  initial begin
    int bc, dc, da;
    logic [6:0] s;
    logic [3:0] a;
    logic [6:0] eh, et;

    vecs[0]  = '{10'd0,    G0, G0, G0, GB, GB};
    vecs[1]  = '{10'd7,    G0, G0, G7, GB, GB};
    vecs[2]  = '{10'd255,  G2, G5, G5, G2, G5};
    vecs[3]  = '{10'd999,  G9, G9, G9, G9, G9};
    vecs[4]  = '{10'd1000, GD, GD, GD, GD, GD};
    vecs[5]  = '{10'd1023, GD, GD, GD, GD, GD};
    vecs[6]  = '{10'd100,  G1, G0, G0, G1, G0};
    vecs[7]  = '{10'd10,   G0, G1, G0, GB, G1};
    vecs[8]  = '{10'd808,  G8, G0, G8, G8, G0};
    vecs[9]  = '{10'd364,  G3, G6, G4, G3, G6};
    vecs[10] = '{10'd46,   G0, G4, G6, GB, G4};
    vecs[11] = '{10'd50,   G0, G5, G0, GB, G5};

    reset       = 1'b1;
    digit       = 2'd0;
    value       = '0;
    value_valid = 1'b0;

    // Reset held for three cycles
    tick(); tick(); tick();
    chk("reset an",   32'(an),   32'(4'b1111));
    chk("reset seg",  32'(seg),  32'(7'b1111111));
    chk("reset busy", 32'(busy), 32'(1'b0));
    chk("reset done", 32'(done), 32'(1'b0));
    reset = 1'b0;
    show(2'd0, s, a);
    chk("post-reset ones seg", 32'(s), 32'(G0));
    chk("post-reset ones an",  32'(a), 32'(4'b1110));
    show(2'd3, s, a);
    chk("digit3 seg", 32'(s), 32'(GB));
    chk("digit3 an",  32'(a), 32'(4'b1111));

    // Table of single conversions
    foreach (vecs[i]) begin
`ifdef LEADING_ZERO_BLANK_EN
      eh = vecs[i].h_lzb;
      et = vecs[i].t_lzb;
`else
      eh = vecs[i].h;
      et = vecs[i].t;
`endif
      convert(vecs[i].value, bc, dc, da);
      chk($sformatf("v%0d busy cycles", vecs[i].value), 32'(bc), 32'd11);
      chk($sformatf("v%0d done count", vecs[i].value),  32'(dc), 32'd1);
      chk($sformatf("v%0d done latency", vecs[i].value), 32'(da), 32'd11);
      check_display($sformatf("v%0d", vecs[i].value), eh, et, vecs[i].o);
    end

    // Second strobe while busy is ignored
    value = 10'd999; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick(); tick();
    value = 10'd42; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    dc = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) dc++;
      tick();
    end
    chk("ignore done count", 32'(dc), 32'd1);
    check_display("ignore", G9, G9, G9);

    // Reset wins over a same-cycle strobe
    reset = 1'b1; value = 10'd321; value_valid = 1'b1;
    tick();
    reset = 1'b0; value_valid = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) bc++;
      if (done) dc++;
      tick();
    end
    chk("rst-prio busy cycles", 32'(bc), 32'd0);
    chk("rst-prio done count",  32'(dc), 32'd0);

    // Reset during SHIFT cycle 5 of value 500
    value = 10'd500; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid-shift busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) bc++;
      if (done) dc++;
      tick();
    end
    chk("mid-shift done count", 32'(dc), 32'd0);
    chk("mid-shift busy after", 32'(bc), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check_display("mid-shift", GB, GB, G0);
`else
    check_display("mid-shift", G0, G0, G0);
`endif
    convert(10'd123, bc, dc, da);
    chk("v123 done count", 32'(dc), 32'd1);
    check_display("v123", G1, G2, G3);

    // Reset on the COMMIT cycle suppresses done and the update
    value = 10'd987; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("commit busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("commit done under reset", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dc++;
      tick();
    end
    chk("commit-reset done count", 32'(dc), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check_display("commit-reset", GB, GB, G0);
`else
    check_display("commit-reset", G0, G0, G0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
